// File: rtl/ifetch_stage.sv
// Instruction fetch stage: issues in-order word fetches, queues responses and presents them to decode.
// Optional performance counters are enabled by defining RVGA_IFETCH_PERF_EN.
module ifetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          FQ_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_v,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_resp_v,
  input  logic [31:0] imem_resp_data,
  input  logic        redirect_v,
  input  logic [31:0] redirect_pc,
  input  logic        decode_stall,
  output logic        ifetch_decode_v,
  output logic [31:0] ifetch_decode_pc,
  output logic [31:0] ifetch_decode_instruction
`ifdef RVGA_IFETCH_PERF_EN
  ,
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_drop_cnt
`endif
);

  localparam int PW = $clog2(FQ_DEPTH);
  localparam int CW = $clog2(FQ_DEPTH + 1);
  localparam logic [PW-1:0] LAST_IDX = PW'(FQ_DEPTH - 1);
  localparam logic [CW-1:0] DEPTH_C  = CW'(FQ_DEPTH);
  localparam logic [31:0]   NOP      = 32'h0000_0013;

  logic [31:0]         fetch_pc_reg;
  logic [31:0]         last_pc_reg;
  logic [PW-1:0]       head_reg, tail_reg, fill_reg;
  logic [CW-1:0]       count_reg, drop_reg, outst_reg;
  logic [31:0]         ent_pc   [FQ_DEPTH];
  logic [31:0]         ent_data [FQ_DEPTH];
  logic [FQ_DEPTH-1:0] ent_filled;

  logic          decode_v, pop, accept, drop_resp, fill, req_v;
  logic [CW-1:0] avail;
  logic          unused_addr_bits;

  // Low address bits of a redirect target are ignored by design.
  assign unused_addr_bits = ^redirect_pc[1:0];

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST_IDX) ? '0 : p + PW'(1);
  endfunction

  assign decode_v  = ent_filled[head_reg] & ~redirect_v;
  assign pop       = decode_v & ~decode_stall;
  // A slot freed by this cycle's pop may be reused immediately for full throughput.
  assign avail     = count_reg - CW'(pop) + drop_reg;
  assign req_v     = rst & ~redirect_v & (avail < DEPTH_C);
  assign accept    = req_v & imem_ready;
  assign drop_resp = imem_resp_v & (redirect_v | (drop_reg != '0));
  assign fill      = imem_resp_v & ~drop_resp;

  assign imem_req_v                = req_v;
  assign imem_addr                 = fetch_pc_reg;
  assign ifetch_decode_v           = decode_v;
  assign ifetch_decode_pc          = decode_v ? ent_pc[head_reg] : last_pc_reg;
  assign ifetch_decode_instruction = decode_v ? ent_data[head_reg] : NOP;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc_reg <= RESET_PC;
      last_pc_reg  <= RESET_PC;
      head_reg     <= '0;
      tail_reg     <= '0;
      fill_reg     <= '0;
      count_reg    <= '0;
      drop_reg     <= '0;
      outst_reg    <= '0;
    end else begin
      if (redirect_v) begin
        head_reg     <= '0;
        tail_reg     <= '0;
        fill_reg     <= '0;
        count_reg    <= '0;
        fetch_pc_reg <= {redirect_pc[31:2], 2'b00};
        // Everything still in flight is stale; a response landing now is already gone.
        drop_reg     <= outst_reg - CW'(imem_resp_v);
      end else begin
        if (accept) begin
          tail_reg     <= ptr_inc(tail_reg);
          fetch_pc_reg <= fetch_pc_reg + 32'd4;
        end
        if (pop) head_reg <= ptr_inc(head_reg);
        if (fill) fill_reg <= ptr_inc(fill_reg);
        count_reg <= count_reg + CW'(accept) - CW'(pop);
        if (imem_resp_v && (drop_reg != '0)) drop_reg <= drop_reg - CW'(1);
      end
      outst_reg <= outst_reg + CW'(accept) - CW'(imem_resp_v);
      if (decode_v) last_pc_reg <= ent_pc[head_reg];
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < FQ_DEPTH; gi++) begin : g_entry
      logic [31:0] pc_reg;
      logic [31:0] data_reg;
      logic        filled_reg;

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          pc_reg     <= '0;
          data_reg   <= '0;
          filled_reg <= 1'b0;
        end else if (redirect_v) begin
          filled_reg <= 1'b0;
        end else begin
          if (fill && (fill_reg == PW'(gi))) begin
            data_reg   <= imem_resp_data;
            filled_reg <= 1'b1;
          end
          if (pop && (head_reg == PW'(gi))) filled_reg <= 1'b0;
          if (accept && (tail_reg == PW'(gi))) begin
            pc_reg     <= fetch_pc_reg;
            filled_reg <= 1'b0;
          end
        end
      end

      assign ent_pc[gi]     = pc_reg;
      assign ent_data[gi]   = data_reg;
      assign ent_filled[gi] = filled_reg;
    end
  endgenerate

`ifdef RVGA_IFETCH_PERF_EN
  logic [31:0] perf_fetch_reg, perf_drop_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_fetch_reg <= '0;
      perf_drop_reg  <= '0;
    end else begin
      if (pop) perf_fetch_reg <= perf_fetch_reg + 32'd1;
      if (drop_resp) perf_drop_reg <= perf_drop_reg + 32'd1;
    end
  end

  assign perf_fetch_cnt = perf_fetch_reg;
  assign perf_drop_cnt  = perf_drop_reg;
`endif

endmodule
